// File: rtl/isp_filter_select.sv
// isp_filter_select: chooses one of NUM_IN filter outputs, together with that filter's own
// data-enable, and registers it for the next ISP stage. The mode is stepped up/down by
// debounced push-buttons. A new mode is applied only at a frame boundary, so frames never tear.
//
// Ports:
//   clk          pixel clock
//   reset        asynchronous active-low reset
//   en           stage enable; 0 forces the bypass input (0) and discards button presses
//   btn_up       raw asynchronous button, next mode
//   btn_down     raw asynchronous button, previous mode
//   frame_start  one-cycle pulse at pixel (0,0)
//   i_data       packed filter outputs, input k at [k*DATA_W +: DATA_W]
//   i_de         per-input data-enable
//   o_data       selected pixel (registered, zero when its data-enable is low)
//   o_de         selected data-enable (registered)
//   o_mode       currently applied mode
//   o_pending    high while the requested mode differs from the applied mode
module isp_filter_select #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned NUM_IN  = 5,
    parameter int unsigned SEL_W   = $clog2(NUM_IN),
    parameter int unsigned DEB_CYC = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     btn_up,
    input  logic                     btn_down,
    input  logic                     frame_start,
    input  logic [NUM_IN*DATA_W-1:0] i_data,
    input  logic [NUM_IN-1:0]        i_de,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_de,
    output logic [SEL_W-1:0]         o_mode,
    output logic                     o_pending
);

    localparam int unsigned CntW = $clog2(DEB_CYC);
    localparam logic [CntW-1:0] CntMax = CntW'(DEB_CYC - 1);
    localparam logic [SEL_W-1:0] ModeMax = SEL_W'(NUM_IN - 1);

    typedef enum logic [0:0] {StIdle, StPending} state_e;

    // Bit 0 is the up button, bit 1 the down button.
    logic [1:0]           btn_raw;
    logic [1:0]           sync1_q, sync2_q, stable_q;
    logic [1:0][CntW-1:0] cnt_q;
    logic [1:0]           press;

    logic [SEL_W-1:0]  req_q, req_d;
    logic [SEL_W-1:0]  mode_q, mode_d;
    logic              pending_q;
    state_e            state_q;
    logic              apply;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] pix;
    logic              pix_de;
    logic [DATA_W-1:0] data_q;
    logic              de_q;

    assign btn_raw = {btn_down, btn_up};

    // Synchroniser plus debounce: a sample that disagrees with the stable level advances the
    // counter, and any agreeing sample clears it, so only an unbroken run of DEB_CYC samples
    // moves the stable level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b] == stable_q[b]) begin
                    cnt_q[b] <= '0;
                end else if (cnt_q[b] == CntMax) begin
                    stable_q[b] <= sync2_q[b];
                    cnt_q[b]    <= '0;
                end else begin
                    cnt_q[b] <= cnt_q[b] + 1'b1;
                end
            end
        end
    end

    // Press fires in the cycle the stable level is about to rise, once per hold.
    always_comb begin
        press = '0;
        for (int b = 0; b < 2; b++) begin
            press[b] = sync2_q[b] && !stable_q[b] && (cnt_q[b] == CntMax);
        end
    end

    // Explicit wrap compares keep the index in range for non-power-of-2 NUM_IN.
    always_comb begin
        req_d = req_q;
        if (en && press[0] && !press[1]) begin
            req_d = (req_q == ModeMax) ? '0 : req_q + SEL_W'(1);
        end else if (en && press[1] && !press[0]) begin
            req_d = (req_q == '0) ? ModeMax : req_q - SEL_W'(1);
        end
    end

    // The mode about to be applied also steers the mux, so the pixel registered on the
    // frame_start edge already comes from the new filter.
    assign apply  = (state_q == StPending) && frame_start && en;
    assign mode_d = apply ? req_q : mode_q;
    assign sel    = en ? mode_d : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            req_q     <= '0;
            mode_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            req_q <= req_d;
            case (state_q)
                StIdle: begin
                    if (req_q != mode_q) begin
                        state_q   <= StPending;
                        pending_q <= 1'b1;
                    end
                end
                StPending: begin
                    if (apply) begin
                        mode_q    <= req_q;
                        pending_q <= 1'b0;
                        state_q   <= StIdle;
                    end else if (req_q == mode_q) begin
                        pending_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pix    = '0;
        pix_de = 1'b0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            if (sel == SEL_W'(k)) begin
                pix    = i_data[k*DATA_W +: DATA_W];
                pix_de = i_de[k];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            de_q   <= 1'b0;
        end else begin
            de_q   <= pix_de;
            data_q <= pix_de ? pix : '0;
        end
    end

    assign o_data    = data_q;
    assign o_de      = de_q;
    assign o_mode    = mode_q;
    assign o_pending = pending_q;

endmodule
